// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter with a start/busy/done handshake.
// Optional parity bit (even, or odd via parity_odd) when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_DEFAULT = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [12:0]           clks_per_bit,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE, PARITY_BIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE} state_t;
`endif
    state_t                state_q, state_d;
    logic [12:0]           clk_cnt_q, clk_cnt_d;
    logic [12:0]           div_q, div_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign last = clk_cnt_q == div_q - 13'd1;
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state and registered-output values; tx_d always carries the level of the slot being entered.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = last ? '0 : clk_cnt_q + 13'd1;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                if (start) begin
                    state_d   = START_BIT;
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    div_d     = clks_per_bit == 13'd0 ? 13'(CLKS_DEFAULT) :
                                clks_per_bit == 13'd1 ? 13'd2 : clks_per_bit;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^data_in ^ parity_odd;
`endif
                end
            end
            START_BIT: begin
                if (last) begin
                    state_d = DATA_BITS;
                    tx_d    = shift_q[0];
                end
            end
            DATA_BITS: begin
                if (last) begin
                    if (bit_cnt_q == 3'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY_BIT;
                        tx_d    = par_q;
`else
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (last) begin
                    state_d = STOP_BIT;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP_BIT: begin
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State register; reset forces the line idle-high at once, aborting any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized frame checks of uart_tx against a slot-level line model.
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] clks_per_bit = '0;
    logic        start = 1'b0;
    logic [7:0]  data_in = '0;
    logic        tx, busy, done;
    logic        par_lat = 1'b0;
    int          tests = 0;
    int          fails = 0;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd = 1'b0;
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [12:0] cpb;
        int          div;
    } vec_t;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk(clk),
        .rst(rst),
        .clks_per_bit(clks_per_bit),
        .start(start),
        .data_in(data_in),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_div(input logic [12:0] cpb);
        return cpb == 13'd0 ? 434 : cpb == 13'd1 ? 2 : int'(cpb);
    endfunction

    // Line level of slot s of a frame: start, 8 data bits LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] d, input int s, input logic p);
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        if (s == NBITS - 1) return 1'b1;
        return (^d) ^ p;
    endfunction

    task automatic launch(input logic [7:0] d, input logic [12:0] cpb, input logic p);
        @(negedge clk);
        start = 1'b1;
        data_in = d;
        clks_per_bit = cpb;
        par_lat = p;
`ifdef UART_TX_PARITY_EN
        parity_odd = p;
`endif
        @(posedge clk);
    endtask

    // Called just after the accepting edge; returns at the negedge of the idle cycle after done.
    task automatic check_frame(input logic [7:0] d, input int div, input logic drop,
                               input logic [7:0] nd, input logic [12:0] ncpb, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int match;
        logic [7:0] rx = '0;
        for (int s = 0; s < NBITS; s++) begin
            match = 0;
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (s == 0 && c == 0) begin
                    if (drop) start = 1'b0;
                    data_in = nd;
                    clks_per_bit = ncpb;
`ifdef UART_TX_PARITY_EN
                    parity_odd = ~par_lat;
`endif
                end
                match += (tx === exp_bit(d, s, par_lat)) ? 1 : 0;
                busy_cnt += (busy === 1'b1) ? 1 : 0;
                done_cnt += (done !== 1'b0) ? 1 : 0;
                if (c == div / 2 && s >= 1 && s <= 8) rx[s-1] = tx;
            end
            chk($sformatf("%s slot%0d", tag, s), match, div);
        end
        chk({tag, " busy_cycles"}, busy_cnt, NBITS * div);
        chk({tag, " early_done"}, done_cnt, 0);
        chk({tag, " rx_byte"}, {24'd0, rx}, {24'd0, d});
        @(negedge clk);
        chk({tag, " done_pulse"}, {29'd0, done, busy, tx}, 32'b101);
        @(negedge clk);
        chk({tag, " after_done"}, {29'd0, done, busy, tx}, 32'b001);
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] lb[4];
        logic [7:0] d;
        logic [12:0] cpb;
        int bad;
        vecs[0] = '{8'hA5, 13'd4, 4};
        vecs[1] = '{8'h81, 13'd1, 2};
        vecs[2] = '{8'h00, 13'd3, 3};
        vecs[3] = '{8'hFF, 13'd2, 2};
        vecs[4] = '{8'h55, 13'd7, 7};
        vecs[5] = '{8'h3C, 13'd0, 434};
        lb = '{8'h00, 8'hFF, 8'h55, 8'h81};

        #1 rst = 1'b0;
        #1;
        chk("reset_async", {29'd0, tx, busy, done}, 32'b100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            bad += (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ? 1 : 0;
        end
        chk("idle_after_reset", bad, 0);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].data, vecs[i].cpb, i[0]);
            check_frame(vecs[i].data, vecs[i].div, 1'b1, ~vecs[i].data, 13'd8, $sformatf("vec%0d", i));
        end

        launch(8'hA5, 13'd4, 1'b0);
        check_frame(8'hA5, 4, 1'b0, 8'h3C, 13'd4, "hold_a5");
        par_lat = ~par_lat;
        check_frame(8'h3C, 4, 1'b1, 8'h00, 13'd9, "b2b_3c");

        launch(8'hFF, 13'd4, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midframe_reset", {29'd0, tx, busy, done}, 32'b100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            bad += (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ? 1 : 0;
        end
        chk("no_done_after_abort", bad, 0);

        launch(8'h00, 13'd4, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("start_bit_low", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("reset_in_start_bit", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        launch(8'hC3, 13'd3, 1'b1);
        check_frame(8'hC3, 3, 1'b1, 8'h00, 13'd5, "post_reset");

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            cpb = 13'($urandom_range(0, 12));
            launch(d, cpb, 1'($urandom));
            check_frame(d, ref_div(cpb), 1'b1, 8'($urandom), 13'($urandom_range(0, 20)), $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            launch(lb[i], 13'd433, 1'b0);
            check_frame(lb[i], 433, 1'b1, 8'h00, 13'd4, $sformatf("loop%0d", i));
        end

`ifdef UART_TX_PARITY_EN
        launch(8'h07, 13'd4, 1'b0);
        check_frame(8'h07, 4, 1'b1, 8'h00, 13'd4, "parity_07");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
